// File: rtl/phy_rx_ms.sv
// USB full/low-speed receive PHY: line sync, bit recovery, NRZI/destuffing, byte assembly, bus-reset detect.
// Optional PHY_RX_MS_ERRCODE_EN adds rx_err_code_o (01 stuffing, 10 SE1, 11 bad EOP / SE0 mid-byte).
module phy_rx_ms #(
  parameter int unsigned BIT_SAMPLES = 4,
  parameter int unsigned LS_FACTOR   = 8,
  parameter int unsigned RST_BITS    = 32
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rx_en_i,
  input  logic       ls_i,
  input  logic       rx_dp_i,
  input  logic       rx_dn_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_err_o,
  output logic       rx_ready_o,
  output logic       usb_reset_o
`ifdef PHY_RX_MS_ERRCODE_EN
  ,
  output logic [1:0] rx_err_code_o
`endif
);

  localparam int unsigned PMAX    = BIT_SAMPLES * LS_FACTOR;
  localparam int unsigned CW      = $clog2(PMAX + 1);
  localparam int unsigned RST_CYC = RST_BITS * BIT_SAMPLES;
  localparam int unsigned RW      = $clog2(RST_CYC + 1);
  localparam int unsigned HOLD    = 4 * BIT_SAMPLES;
  localparam int unsigned HW      = $clog2(HOLD + 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_SE1   = 2'b10;
  localparam logic [1:0] ERR_EOP   = 2'b11;

  typedef enum logic [1:0] {L_SE0 = 2'd0, L_J = 2'd1, L_K = 2'd2, L_SE1 = 2'd3} line_e;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} state_e;

  logic [1:0]    dp_sync, dn_sync;
  logic          dp_h, dn_h;
  logic          en_q, ls_q;
  logic [CW-1:0] phase, period_c;
  logic          edge_c, strobe_c, bit_c;
  line_e         line_c, line_q;
  state_e        state;
  logic [2:0]    alt_cnt, bit_cnt, ones_cnt;
  logic [1:0]    se0_bits;
  logic [6:0]    shreg;
  logic [1:0]    abort_c;
  logic [RW-1:0] se0_run;
  logic [HW-1:0] hold_cnt;

  // Two-flop synchronizers, history flops for edge detection, speed latch on enable rise
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dp_sync <= 2'b00;
      dn_sync <= 2'b00;
      dp_h    <= 1'b0;
      dn_h    <= 1'b0;
      en_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      dp_sync <= {dp_sync[0], rx_dp_i};
      dn_sync <= {dn_sync[0], rx_dn_i};
      dp_h    <= dp_sync[1];
      dn_h    <= dn_sync[1];
      en_q    <= rx_en_i;
      if (rx_en_i && !en_q) ls_q <= ls_i;
    end
  end

  assign edge_c = (dp_sync[1] != dp_h) || (dn_sync[1] != dn_h);

  // J/K polarity swaps with the latched speed
  always_comb begin
    line_c = L_SE0;
    case ({dp_sync[1], dn_sync[1]})
      2'b00:   line_c = L_SE0;
      2'b11:   line_c = L_SE1;
      2'b10:   line_c = ls_q ? L_K : L_J;
      default: line_c = ls_q ? L_J : L_K;
    endcase
  end

  assign period_c = ls_q ? CW'(PMAX) : CW'(BIT_SAMPLES);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase <= '0;
    end else if (edge_c || phase >= period_c - CW'(1)) begin
      phase <= '0;
    end else begin
      phase <= phase + CW'(1);
    end
  end

  assign strobe_c = (phase == (period_c >> 1) - CW'(1)) && !edge_c;
  assign bit_c    = (line_c == line_q);

  // Abort classification at a sample strobe; any nonzero code sends the FSM to ERR
  always_comb begin
    abort_c = ERR_NONE;
    if (strobe_c) begin
      case (state)
        DATA: begin
          if (line_c == L_SE1) begin
            abort_c = ERR_SE1;
          end else if (line_c == L_SE0) begin
            if (bit_cnt > 3'd1) abort_c = ERR_EOP;
          end else if (ones_cnt == 3'd6 && bit_c) begin
            abort_c = ERR_STUFF;
          end
        end
        EOP: begin
          if (line_c == L_SE1) begin
            abort_c = ERR_SE1;
          end else if (line_c == L_K || (line_c == L_SE0 && se0_bits == 2'd2)) begin
            abort_c = ERR_EOP;
          end
        end
        default: abort_c = ERR_NONE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      line_q     <= L_SE0;
      alt_cnt    <= '0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      se0_bits   <= '0;
      shreg      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      rx_ready_o <= 1'b0;
    end else if (!rx_en_i) begin
      state      <= IDLE;
      line_q     <= L_SE0;
      alt_cnt    <= '0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      se0_bits   <= '0;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      rx_ready_o <= 1'b0;
    end else begin
      rx_ready_o <= 1'b0;
      if (state == IDLE) rx_err_o <= 1'b0;
      if (strobe_c) begin
        line_q <= line_c;
        if (abort_c != ERR_NONE) begin
          state      <= ERR;
          rx_valid_o <= 1'b0;
          rx_err_o   <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (line_q == L_J && line_c == L_K) begin
                state   <= SYNC;
                alt_cnt <= '0;
              end
            end
            SYNC: begin
              if (line_c == L_SE0 || line_c == L_SE1) begin
                state <= IDLE;
              end else if (line_c == line_q) begin
                if (line_c == L_K && alt_cnt >= 3'd5) begin
                  state      <= DATA;
                  rx_valid_o <= 1'b1;
                  bit_cnt    <= '0;
                  ones_cnt   <= '0;
                end else begin
                  state <= IDLE;
                end
              end else if (alt_cnt != 3'd7) begin
                alt_cnt <= alt_cnt + 3'd1;
              end
            end
            DATA: begin
              if (line_c == L_SE0) begin
                state      <= EOP;
                rx_valid_o <= 1'b0;
                se0_bits   <= 2'd1;
              end else if (ones_cnt == 3'd6) begin
                ones_cnt <= '0;
              end else begin
                ones_cnt <= bit_c ? ones_cnt + 3'd1 : 3'd0;
                shreg    <= {bit_c, shreg[6:1]};
                if (bit_cnt == 3'd7) begin
                  rx_data_o  <= {bit_c, shreg};
                  rx_ready_o <= 1'b1;
                  bit_cnt    <= '0;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
            end
            EOP: begin
              if (line_c == L_J) begin
                rx_ready_o <= 1'b1;
                state      <= IDLE;
              end else begin
                se0_bits <= se0_bits + 2'd1;
              end
            end
            ERR: begin
              rx_ready_o <= 1'b1;
              state      <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Bus reset: long SE0 run, minimum high time, release on first non-SE0 sample
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      se0_run     <= '0;
      hold_cnt    <= '0;
      usb_reset_o <= 1'b0;
    end else if (!rx_en_i) begin
      se0_run     <= '0;
      hold_cnt    <= '0;
      usb_reset_o <= 1'b0;
    end else begin
      if (line_c == L_SE0) begin
        if (se0_run != RW'(RST_CYC)) se0_run <= se0_run + RW'(1);
      end else begin
        se0_run <= '0;
      end
      if (!usb_reset_o) begin
        hold_cnt <= '0;
        if (line_c == L_SE0 && se0_run == RW'(RST_CYC - 1)) usb_reset_o <= 1'b1;
      end else begin
        if (hold_cnt != HW'(HOLD)) hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt >= HW'(HOLD - 1) && line_c != L_SE0) usb_reset_o <= 1'b0;
      end
    end
  end

`ifdef PHY_RX_MS_ERRCODE_EN
  // Error code tracks rx_err_o: captured on abort, cleared once back in IDLE
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_err_code_o <= ERR_NONE;
    end else if (!rx_en_i || state == IDLE) begin
      rx_err_code_o <= ERR_NONE;
    end else if (abort_c != ERR_NONE) begin
      rx_err_code_o <= abort_c;
    end
  end
`endif

endmodule

// File: doc/phy_rx_ms.md
PHY_RX_MS -- requirements
Module: phy_rx_ms

Interface
REQ-001 SHALL have parameter BIT_SAMPLES, default 4, clk_i cycles per full-speed bit; even, >=4.
REQ-002 SHALL have parameter LS_FACTOR, default 8, low-speed to full-speed bit period ratio.
REQ-003 SHALL have parameter RST_BITS, default 32, consecutive full-speed bit times of SE0 that signal USB reset.
REQ-004 clk_i  input  1  clock at 12MHz*BIT_SAMPLES.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 rx_en_i  input  1  receiver enable; low forces IDLE.
REQ-007 ls_i  input  1  1=low-speed, 0=full-speed; latched on rx_en_i rising edge.
REQ-008 rx_dp_i, rx_dn_i  input  1 each  asynchronous line receivers.
REQ-009 rx_data_o  output  8  received byte, LSB first on the wire.
REQ-010 rx_valid_o  output  1  high while a packet byte is being assembled.
REQ-011 rx_err_o  output  1  packet aborted.
REQ-012 rx_ready_o  output  1  one-cycle strobe qualifying data, error or EOP.
REQ-013 usb_reset_o  output  1  USB bus reset detected.

Function
REQ-014 Each of dp and dn SHALL pass a 2-flop synchronizer plus one history flop for edge detection.
REQ-015 Line states SHALL decode as SE0 (0,0) and SE1 (1,1); J=(dp=1,dn=0) in full speed and (0,1) in low speed; K is the opposite.
REQ-016 Bit period P SHALL be BIT_SAMPLES (fs) or BIT_SAMPLES*LS_FACTOR (ls); the phase counter clears on any synchronized dp/dn transition, wraps at P-1, and asserts a sample strobe at count P/2-1.
REQ-017 The state machine SHALL have states IDLE, SYNC, DATA, EOP, ERR, advancing only on sample strobes.
REQ-018 IDLE->SYNC on a sampled J followed by K.
REQ-019 SYNC: each alternation counts; two consecutive K after >=5 alternations -> DATA with rx_valid_o high; SE0, SE1, or KK after fewer alternations -> IDLE silently.
REQ-020 NRZI: unchanged state=1, changed=0; the bit following six consecutive 1s SHALL be a 0, discarded; a seventh 1 -> ERR.
REQ-021 On the 8th destuffed bit rx_data_o SHALL update and rx_ready_o SHALL pulse in the same cycle with rx_valid_o high.
REQ-022 SE0 in DATA with 0 or 1 pending bits (1 = dribble, discarded) -> EOP; with 2-7 pending bits -> ERR.
REQ-023 EOP: J after 1 or 2 SE0 bit times -> rx_ready_o pulse with rx_valid_o=0, rx_err_o=0, then IDLE; a 3rd SE0 bit, K or SE1 -> ERR.
REQ-024 SE1 in DATA -> ERR.
REQ-025 ERR SHALL hold for one bit period with rx_err_o high and rx_valid_o low, pulse rx_ready_o once, then go to IDLE.
REQ-026 rx_valid_o SHALL fall at the sample strobe that detects EOP or error, before the terminating rx_ready_o.
REQ-027 usb_reset_o SHALL assert after RST_BITS*BIT_SAMPLES consecutive SE0 cycles, independent of ls_i, while rx_en_i is high.
REQ-028 usb_reset_o SHALL stay high >=4*BIT_SAMPLES cycles, then deassert on the first non-SE0 sample.
REQ-029 rx_en_i low SHALL force IDLE and hold rx_valid_o, rx_err_o, rx_ready_o and usb_reset_o low within one cycle.
REQ-030 The latched speed SHALL NOT change while rx_en_i is high.

Reset
REQ-031 On rstn_i low: state IDLE, all counters 0, rx_data_o=0, rx_valid_o/rx_err_o/rx_ready_o/usb_reset_o=0, speed latch=0.
REQ-032 Reset asserted mid-packet SHALL discard the packet with no rx_ready_o pulse.

Configuration
REQ-033 With PHY_RX_MS_ERRCODE_EN defined, output rx_err_code_o[1:0] SHALL exist: 01 stuffing, 10 SE1, 11 bad EOP/SE0 mid-byte; valid while rx_err_o is high, else 00.
REQ-034 Without PHY_RX_MS_ERRCODE_EN, the port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 FS, BIT_SAMPLES=4: SYNC + bytes 0xC3,0x5A + SE0 SE0 J -> two rx_ready_o pulses with data C3, 5A, then one EOP pulse with valid=0, err=0.
REQ-036 LS, ls_i=1 latched: same packet at 32 cycles/bit with J/K swapped -> identical handshake sequence.
REQ-037 Byte 0xFF with stuff bit inserted -> data FF; stuff bit omitted (seven 1s) -> rx_err_o with rx_ready_o pulse, code 01 when macro defined.
REQ-038 SE0 after 3 bits of a byte -> ERR, code 11; one dribble bit before SE0 -> clean EOP.
REQ-039 SE0 held 128 cycles (BIT_SAMPLES=4) -> usb_reset_o high at cycle 128; J after 2 more cycles -> held until >=16 cycles high, then low.
REQ-040 rstn_i pulsed low mid-byte -> all outputs 0 immediately, no rx_ready_o, next packet received correctly.
